// File: rtl/mul_if.sv
// Multiplier request/writeback bundle: operands and controls from the issue side,
// and a result/index/active-low load-enable shaped like the register file write port.
interface mul_if #(
    parameter int WIDTH = 32,
    parameter int RW    = 4
);
    logic             start;
    logic             accumulate;
    logic             set_flags;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic [RW-1:0]    rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [RW-1:0]    rd_out;
    logic             le_out;
    logic             n_flag;
    logic             z_flag;

    modport master (
        output start, accumulate, set_flags, op_a, op_b, op_c, rd_in,
        input  busy, done, result, rd_out, le_out, n_flag, z_flag
    );

    modport slave (
        input  start, accumulate, set_flags, op_a, op_b, op_c, rd_in,
        output busy, done, result, rd_out, le_out, n_flag, z_flag
    );
endinterface

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier (MUL/MLA) with early termination once the
// remaining multiplier bits are all zero; writeback shaped for the register file.
module mul_unit #(
    parameter int WIDTH = 32,
    parameter int RW    = 4
) (
    input  logic clk,
    input  logic clr,
    mul_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplr_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_sum_s;
    logic [WIDTH-1:0] mplr_shift_s;
    logic [RW-1:0]    rd_r;
    logic             sf_r;
    logic [WIDTH-1:0] result_r;
    logic [RW-1:0]    rd_out_r;
    logic             n_r;
    logic             z_r;
    logic             busy_r;
    logic             done_r;
    logic             le_r;

    // Next-state decode and the single shift-add step of the datapath
    always_comb begin
        state_next_s = state_r;
        mplr_shift_s = {1'b0, mplr_r[WIDTH-1:1]};
        if (mplr_r[0]) begin
            acc_sum_s = acc_r + mcand_r;
        end else begin
            acc_sum_s = acc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Finish as soon as no set multiplier bits remain to be consumed
                if (mplr_shift_s == '0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            le_r   <= 1'b1;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
            le_r   <= (state_next_s != ST_DONE);
        end
    end

    // Operand capture, iteration and result/flag writeback
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mcand_r  <= '0;
            mplr_r   <= '0;
            acc_r    <= '0;
            rd_r     <= '0;
            sf_r     <= 1'b0;
            result_r <= '0;
            rd_out_r <= '0;
            n_r      <= 1'b0;
            z_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_r <= bus.op_a;
                        mplr_r  <= bus.op_b;
                        acc_r   <= bus.accumulate ? bus.op_c : '0;
                        rd_r    <= bus.rd_in;
                        sf_r    <= bus.set_flags;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_sum_s;
                    mcand_r <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplr_r  <= mplr_shift_s;
                    if (mplr_shift_s == '0) begin
                        result_r <= acc_sum_s;
                        rd_out_r <= rd_r;
                        if (sf_r) begin
                            n_r <= acc_sum_s[WIDTH-1];
                            z_r <= (acc_sum_s == '0);
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.le_out = le_r;
    assign bus.result = result_r;
    assign bus.rd_out = rd_out_r;
    assign bus.n_flag = n_r;
    assign bus.z_flag = z_r;
endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed scenarios plus randomized MUL/MLA operations
// compared against a plain-arithmetic product/latency/flag model.
module tb_mul_unit;
    localparam int WIDTH = 32;
    localparam int RW    = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    mul_if #(.WIDTH(WIDTH), .RW(RW)) mif ();
    mul_unit #(.WIDTH(WIDTH), .RW(RW)) dut (.clk(clk), .clr(clr), .bus(mif));

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_n     = 1'b0;
    logic exp_z     = 1'b0;

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic acc);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (acc) p = p + {32'd0, c};
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // Issue one operation and wait (bounded) for done; lat = edges after the start edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic acc, input logic sf, input logic [3:0] rd,
                         output int lat, output logic busy_ok);
        @(negedge clk);
        mif.op_a = a; mif.op_b = b; mif.op_c = c;
        mif.accumulate = acc; mif.set_flags = sf; mif.rd_in = rd; mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        mif.op_a = $urandom; mif.op_b = $urandom; mif.op_c = $urandom;
        mif.accumulate = ~acc; mif.set_flags = ~sf; mif.rd_in = 4'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (mif.done !== 1'b1 && lat < 40) begin
            if (mif.busy !== 1'b1 || mif.le_out !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (sf) begin
            exp_n = ref_result(a, b, c, acc) >> 31;
            exp_z = (ref_result(a, b, c, acc) == 32'd0);
        end
    endtask

    task automatic test_reset();
        mif.start = 1'b0; mif.accumulate = 1'b0; mif.set_flags = 1'b0;
        mif.op_a = 32'd0; mif.op_b = 32'd0; mif.op_c = 32'd0; mif.rd_in = 4'd0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", mif.busy); else pass_cnt++;
        total_cnt++; if (mif.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", mif.done); else pass_cnt++;
        total_cnt++; if (mif.le_out !== 1'b1) $display("FAIL reset_le: got %b expected 1", mif.le_out); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'd0) $display("FAIL reset_result: got %h expected 0", mif.result); else pass_cnt++;
        total_cnt++; if ({mif.rd_out, mif.n_flag, mif.z_flag} !== 6'd0) $display("FAIL reset_rd_flags: got %b expected 0", {mif.rd_out, mif.n_flag, mif.z_flag}); else pass_cnt++;
        clr = 1'b1;
    endtask

    task automatic test_mul();
        int lat; logic bok;
        do_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'h3, lat, bok);
        total_cnt++; if (lat !== 3) $display("FAIL mul_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (bok !== 1'b1) $display("FAIL mul_busy_run: got %b expected 1", bok); else pass_cnt++;
        total_cnt++; if ({mif.busy, mif.le_out} !== 2'b00) $display("FAIL mul_done_status: got busy/le %b expected 00", {mif.busy, mif.le_out}); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'h2A) $display("FAIL mul_result: got %h expected 0000002a", mif.result); else pass_cnt++;
        total_cnt++; if (mif.rd_out !== 4'h3) $display("FAIL mul_rd: got %h expected 3", mif.rd_out); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({mif.done, mif.le_out} !== 2'b01) $display("FAIL mul_done_width: got done/le %b expected 01", {mif.done, mif.le_out}); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'h2A) $display("FAIL mul_hold: got %h expected 0000002a", mif.result); else pass_cnt++;
    endtask

    task automatic test_mla();
        int lat; logic bok;
        do_op(32'd3, 32'd5, 32'd10, 1'b1, 1'b1, 4'h7, lat, bok);
        total_cnt++; if (lat !== 3) $display("FAIL mla_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'h19) $display("FAIL mla_result: got %h expected 00000019", mif.result); else pass_cnt++;
        total_cnt++; if ({mif.n_flag, mif.z_flag} !== 2'b00) $display("FAIL mla_flags: got %b expected 00", {mif.n_flag, mif.z_flag}); else pass_cnt++;
    endtask

    task automatic test_zero();
        int lat; logic bok;
        do_op(32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 4'h1, lat, bok);
        total_cnt++; if (lat !== 1) $display("FAIL zero_latency: got %0d expected 1", lat); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'd0) $display("FAIL zero_result: got %h expected 0", mif.result); else pass_cnt++;
        total_cnt++; if ({mif.n_flag, mif.z_flag} !== 2'b01) $display("FAIL zero_flags: got %b expected 01", {mif.n_flag, mif.z_flag}); else pass_cnt++;
    endtask

    task automatic test_wrap_sign();
        int lat; logic bok;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 4'h2, lat, bok);
        total_cnt++; if (lat !== 32) $display("FAIL wrap_latency: got %0d expected 32", lat); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'd1) $display("FAIL wrap_result: got %h expected 00000001", mif.result); else pass_cnt++;
        total_cnt++; if ({mif.n_flag, mif.z_flag} !== 2'b01) $display("FAIL wrap_flags_kept: got %b expected 01", {mif.n_flag, mif.z_flag}); else pass_cnt++;
        do_op(32'h80000000, 32'd1, 32'd0, 1'b0, 1'b1, 4'h9, lat, bok);
        total_cnt++; if (lat !== 1) $display("FAIL sign_latency: got %0d expected 1", lat); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'h80000000) $display("FAIL sign_result: got %h expected 80000000", mif.result); else pass_cnt++;
        total_cnt++; if ({mif.n_flag, mif.z_flag} !== 2'b10) $display("FAIL sign_flags: got %b expected 10", {mif.n_flag, mif.z_flag}); else pass_cnt++;
    endtask

    task automatic test_ignore();
        int lat; int dones;
        @(negedge clk);
        mif.op_a = 32'd5; mif.op_b = 32'hFF; mif.op_c = 32'd0; mif.accumulate = 1'b0;
        mif.set_flags = 1'b0; mif.rd_in = 4'hA; mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (2) @(negedge clk);
        mif.op_a = 32'd1234; mif.op_b = 32'd3; mif.op_c = 32'd99; mif.accumulate = 1'b1;
        mif.rd_in = 4'h5; mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        lat = 3;
        while (mif.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        total_cnt++; if (lat !== 8) $display("FAIL ignore_latency: got %0d expected 8", lat); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'd1275) $display("FAIL ignore_result: got %h expected %h", mif.result, 32'd1275); else pass_cnt++;
        total_cnt++; if (mif.rd_out !== 4'hA) $display("FAIL ignore_rd: got %h expected a", mif.rd_out); else pass_cnt++;
        dones = 0;
        repeat (6) begin @(negedge clk); if (mif.done === 1'b1 || mif.busy === 1'b1) dones++; end
        total_cnt++; if (dones !== 0) $display("FAIL ignore_no_queue: got %0d active cycles expected 0", dones); else pass_cnt++;
    endtask

    task automatic test_abort();
        int bad;
        @(negedge clk);
        mif.op_a = 32'h12345678; mif.op_b = 32'hFFFFFFFF; mif.accumulate = 1'b0;
        mif.set_flags = 1'b1; mif.rd_in = 4'hC; mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (5) @(negedge clk);
        clr = 1'b0;
        #1;
        total_cnt++; if ({mif.busy, mif.done, mif.le_out} !== 3'b001) $display("FAIL abort_immediate: got busy/done/le %b expected 001", {mif.busy, mif.done, mif.le_out}); else pass_cnt++;
        total_cnt++; if (mif.result !== 32'd0) $display("FAIL abort_result: got %h expected 0", mif.result); else pass_cnt++;
        bad = 0;
        repeat (40) begin @(negedge clk); if (mif.done !== 1'b0 || mif.le_out !== 1'b1) bad++; end
        clr = 1'b1;
        repeat (3) begin @(negedge clk); if (mif.done !== 1'b0 || mif.le_out !== 1'b1 || mif.busy !== 1'b0) bad++; end
        total_cnt++; if (bad !== 0) $display("FAIL abort_no_write: got %0d bad cycles expected 0", bad); else pass_cnt++;
        exp_n = 1'b0; exp_z = 1'b0;
    endtask

    task automatic test_random();
        int lat; logic bok;
        logic [31:0] a, b, c, er; logic acc, sf; logic [3:0] rd;
        for (int k = 0; k < 24; k++) begin
            a = $urandom; b = $urandom >> $urandom_range(0, 31); c = $urandom;
            acc = 1'($urandom); sf = 1'($urandom); rd = 4'($urandom);
            if (k == 0) b = 32'd1;
            er = ref_result(a, b, c, acc);
            do_op(a, b, c, acc, sf, rd, lat, bok);
            total_cnt++; if (lat !== ref_lat(b)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, ref_lat(b)); else pass_cnt++;
            total_cnt++; if (mif.result !== er) $display("FAIL rand_result[%0d]: got %h expected %h", k, mif.result, er); else pass_cnt++;
            total_cnt++; if ({mif.rd_out, mif.le_out, bok} !== {rd, 1'b0, 1'b1}) $display("FAIL rand_wb[%0d]: got rd/le/busy %h/%b/%b expected %h/0/1", k, mif.rd_out, mif.le_out, bok, rd); else pass_cnt++;
            total_cnt++; if ({mif.n_flag, mif.z_flag} !== {exp_n, exp_z}) $display("FAIL rand_flags[%0d]: got %b expected %b", k, {mif.n_flag, mif.z_flag}, {exp_n, exp_z}); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mla();
        test_zero();
        test_wrap_sign();
        test_ignore();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
